// File: rtl/serv_pc_sequencer_pkg.sv
// Shared types for the serial PC sequencer: FSM state encoding, counter width and strobe bundle.
package serv_pc_sequencer_pkg;

  localparam int CNT_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RF,
    INIT,
    RUN
  } state_t;

  typedef struct packed {
    logic cnt0;
    logic cnt1;
    logic cnt2;
    logic cnt03;
    logic cnt12to31;
    logic done;
  } cnt_strb_t;

endpackage

// File: rtl/serv_pc_sequencer_cnt.sv
// Serial step counter (advances W bits per enabled cycle) plus combinational strobe decode.
// Strobes are valid in the same cycle as cnt_en; no stall input, a pass always runs to completion.
module serv_pc_sequencer_cnt
  import serv_pc_sequencer_pkg::*;
#(
  parameter int W = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      cnt_en,
  output cnt_strb_t strb
);

  localparam logic [CNT_W-1:0] STEP = CNT_W'(W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(32 - W);

  logic [CNT_W-1:0] cnt;

  // The 5-bit add wraps to zero on the last step, so an idle counter always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_en) begin
      cnt <= cnt + STEP;
    end else begin
      cnt <= '0;
    end
  end

  always_comb begin
    strb           = '0;
    strb.cnt0      = cnt_en & (cnt == 5'd0);
    strb.cnt1      = (W == 1) & cnt_en & (cnt == 5'd1);
    strb.cnt2      = (W == 1) & cnt_en & (cnt == 5'd2);
    strb.cnt03     = cnt_en & (cnt < 5'd4);
    strb.cnt12to31 = cnt_en & (cnt >= 5'd12);
    strb.done      = cnt_en & (cnt == LAST);
  end

endmodule

// File: rtl/serv_pc_sequencer.sv
// Per-instruction sequencer: fetch, RF read request, optional INIT pass, RUN pass; latches jump/trap.
// Ack-to-first-pc_en is 2 cycles single-stage, +32/W two-stage; waits indefinitely on ibus ack and rf ready.
module serv_pc_sequencer
  import serv_pc_sequencer_pkg::*;
#(
  parameter int W        = 1,
  parameter bit WITH_CSR = 1'b1
) (
  input  logic clk,
  input  logic i_rst,
  output logic o_ibus_cyc,
  input  logic i_ibus_ack,
  output logic o_rf_rreq,
  input  logic i_rf_ready,
  input  logic i_two_stage,
  input  logic i_branch_op,
  input  logic i_jal_or_jalr,
  input  logic i_cond,
  input  logic i_misalign,
  input  logic i_trap_req,
  output logic o_init,
  output logic o_pc_en,
  output logic o_cnt_en,
  output logic o_cnt0,
  output logic o_cnt1,
  output logic o_cnt2,
  output logic o_cnt03,
  output logic o_cnt12to31,
  output logic o_cnt_done,
  output logic o_jump,
  output logic o_trap
);

  localparam logic CSR_EN = WITH_CSR;

  state_t    state;
  state_t    state_n;
  cnt_strb_t strb;
  logic      cnt_en;
  logic      rreq_seen;
  logic      trap_pend;
  logic      jump_q;
  logic      trap_q;
  logic      jump_n;
  logic      trap_sample;

  serv_pc_sequencer_cnt #(.W(W)) u_cnt (
    .clk    (clk),
    .rst    (i_rst),
    .cnt_en (cnt_en),
    .strb   (strb)
  );

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = FETCH;
      FETCH:   if (i_ibus_ack) state_n = WAIT_RF;
      WAIT_RF: if (i_rf_ready) state_n = i_two_stage ? INIT : RUN;
      INIT:    if (strb.done) state_n = RUN;
      RUN:     if (strb.done) state_n = FETCH;
      default: state_n = IDLE;
    endcase
  end

  assign cnt_en      = (state == INIT) || (state == RUN);
  assign jump_n      = i_jal_or_jalr | (i_branch_op & i_cond);
  // Includes the current cycle so a trap raised on the rf_ready cycle is not lost.
  assign trap_sample = CSR_EN & (trap_pend | i_trap_req);

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rreq_seen <= 1'b0;
      trap_pend <= 1'b0;
      jump_q    <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      rreq_seen <= (state == WAIT_RF);
      case (state)
        WAIT_RF: begin
          trap_pend <= trap_sample;
          if (i_rf_ready && !i_two_stage) begin
            jump_q <= 1'b0;
            trap_q <= trap_sample;
          end
        end
        INIT: begin
          if (strb.done) begin
            jump_q <= jump_n;
            trap_q <= CSR_EN & (trap_pend | (jump_n & i_misalign));
          end
        end
        RUN: begin
          if (strb.done) begin
            jump_q    <= 1'b0;
            trap_q    <= 1'b0;
            trap_pend <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ibus_cyc  = (state == FETCH);
  assign o_rf_rreq   = (state == WAIT_RF) && !rreq_seen;
  assign o_init      = (state == INIT);
  assign o_pc_en     = (state == RUN);
  assign o_cnt_en    = cnt_en;
  assign o_cnt0      = strb.cnt0;
  assign o_cnt1      = strb.cnt1;
  assign o_cnt2      = strb.cnt2;
  assign o_cnt03     = strb.cnt03;
  assign o_cnt12to31 = strb.cnt12to31;
  assign o_cnt_done  = strb.done;
  assign o_jump      = jump_q;
  assign o_trap      = trap_q & CSR_EN;

endmodule

// File: tb/tb_serv_pc_sequencer.sv
// Scoreboard bench for serv_pc_sequencer: three configurations (W=1/CSR, W=4/CSR, W=1/no CSR).
module tb_serv_pc_sequencer;

  typedef logic [12:0] vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic ack = 1'b0, rf_ready = 1'b0, two_stage = 1'b0, branch_op = 1'b0;
  logic jal = 1'b0, cond = 1'b0, misalign = 1'b0, trap_req = 1'b0;
  int   sel = 0;

  // Observation vector: cyc rreq init pc_en cnt_en cnt0 cnt1 cnt2 cnt03 cnt12to31 done jump trap
  wire [12:0] ob0, ob1, ob2;
  vec_t obs;

  always_comb begin
    obs = ob0;
    if (sel == 1) obs = ob1;
    if (sel == 2) obs = ob2;
  end

  serv_pc_sequencer #(.W(1), .WITH_CSR(1'b1)) dut_a (
    .clk(clk), .i_rst(rst_a), .o_ibus_cyc(ob0[12]), .i_ibus_ack(ack), .o_rf_rreq(ob0[11]),
    .i_rf_ready(rf_ready), .i_two_stage(two_stage), .i_branch_op(branch_op), .i_jal_or_jalr(jal),
    .i_cond(cond), .i_misalign(misalign), .i_trap_req(trap_req), .o_init(ob0[10]), .o_pc_en(ob0[9]),
    .o_cnt_en(ob0[8]), .o_cnt0(ob0[7]), .o_cnt1(ob0[6]), .o_cnt2(ob0[5]), .o_cnt03(ob0[4]),
    .o_cnt12to31(ob0[3]), .o_cnt_done(ob0[2]), .o_jump(ob0[1]), .o_trap(ob0[0]));

  serv_pc_sequencer #(.W(4), .WITH_CSR(1'b1)) dut_b (
    .clk(clk), .i_rst(rst_b), .o_ibus_cyc(ob1[12]), .i_ibus_ack(ack), .o_rf_rreq(ob1[11]),
    .i_rf_ready(rf_ready), .i_two_stage(two_stage), .i_branch_op(branch_op), .i_jal_or_jalr(jal),
    .i_cond(cond), .i_misalign(misalign), .i_trap_req(trap_req), .o_init(ob1[10]), .o_pc_en(ob1[9]),
    .o_cnt_en(ob1[8]), .o_cnt0(ob1[7]), .o_cnt1(ob1[6]), .o_cnt2(ob1[5]), .o_cnt03(ob1[4]),
    .o_cnt12to31(ob1[3]), .o_cnt_done(ob1[2]), .o_jump(ob1[1]), .o_trap(ob1[0]));

  serv_pc_sequencer #(.W(1), .WITH_CSR(1'b0)) dut_c (
    .clk(clk), .i_rst(rst_c), .o_ibus_cyc(ob2[12]), .i_ibus_ack(ack), .o_rf_rreq(ob2[11]),
    .i_rf_ready(rf_ready), .i_two_stage(two_stage), .i_branch_op(branch_op), .i_jal_or_jalr(jal),
    .i_cond(cond), .i_misalign(misalign), .i_trap_req(trap_req), .o_init(ob2[10]), .o_pc_en(ob2[9]),
    .o_cnt_en(ob2[8]), .o_cnt0(ob2[7]), .o_cnt1(ob2[6]), .o_cnt2(ob2[5]), .o_cnt03(ob2[4]),
    .o_cnt12to31(ob2[3]), .o_cnt_done(ob2[2]), .o_jump(ob2[1]), .o_trap(ob2[0]));

  vec_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   popped = 0;
  logic prev_run_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  // Expected observation for pass step s (W bits per step, 32/W steps per pass).
  function automatic vec_t mk(input bit rreq, input bit init, input bit run, input int w,
                              input int s, input bit j, input bit t);
    vec_t v;
    int   n;
    v     = '0;
    n     = 32 / w;
    v[11] = rreq;
    v[10] = init;
    v[9]  = run;
    v[8]  = init | run;
    if (init | run) begin
      v[7] = (s == 0);
      v[6] = (w == 1) && (s == 1);
      v[5] = (w == 1) && (s == 2);
      v[4] = (s * w < 4);
      v[3] = (s * w >= 12);
      v[2] = (s == n - 1);
    end
    v[1] = j;
    v[0] = t;
    return v;
  endfunction

  // Monitor: every cycle with rreq or cnt_en pops one expected vector.
  always @(negedge clk) begin
    if (prev_run_done) check("after_run_done{cyc,jump,trap}", {29'd0, obs[12], obs[1], obs[0]}, 32'b100);
    prev_run_done = obs[2] & obs[9];
    if (obs[11] | obs[8]) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_event: got %b expected no activity", obs);
      end else begin
        check($sformatf("seq_event_%0d", popped), {19'd0, obs}, {19'd0, q.pop_front()});
        popped++;
      end
    end
  end

  task automatic run_instr(input int w, input bit ts, input bit br, input bit jl, input bit cd,
                           input bit ma, input bit tr, input int ack_dly, input int rf_dly,
                           input bit ej, input bit et, input int abort_at);
    int  n;
    int  run_steps;
    bool_found: begin end
    n         = 32 / w;
    run_steps = (abort_at < 0) ? n : abort_at;
    two_stage = ts; branch_op = br; jal = jl; cond = cd; misalign = ma; trap_req = tr;
    rf_ready  = (rf_dly == 0);
    begin : wait_fetch
      for (int k = 0; k < 100; k++) begin
        @(negedge clk); #1;
        if (obs[12]) disable wait_fetch;
      end
      checks++;
      $display("FAIL fetch_timeout: got cyc=0 for 100 cycles expected cyc=1");
      return;
    end
    repeat (ack_dly - 1) @(negedge clk);
    ack = 1'b1;
    q.push_back(mk(1'b1, 1'b0, 1'b0, w, 0, 1'b0, 1'b0));
    if (ts) for (int s = 0; s < n; s++) q.push_back(mk(1'b0, 1'b1, 1'b0, w, s, 1'b0, 1'b0));
    for (int s = 0; s < run_steps; s++) q.push_back(mk(1'b0, 1'b0, 1'b1, w, s, ej, et));
    @(negedge clk);
    ack = 1'b0;
    if (rf_dly > 0) begin
      repeat (rf_dly) @(negedge clk);
      rf_ready = 1'b1;
    end
    begin : wait_drain
      for (int k = 0; k < 300; k++) begin
        @(posedge clk); #1;
        if (q.size() == 0) disable wait_drain;
      end
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
      return;
    end
    if (abort_at < 0) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    @(negedge clk);
    check("reset_a", {19'd0, ob0}, 32'd0);
    check("reset_b", {19'd0, ob1}, 32'd0);
    check("reset_c", {19'd0, ob2}, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0;

    // W=1 with CSR: single-stage, branches, jal misalign, traps, back-to-back
    run_instr(1, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, -1);
    run_instr(1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, -1);
    run_instr(1, 1, 0, 1, 0, 1, 0, 2, 0, 1, 1, -1);
    run_instr(1, 1, 1, 0, 0, 1, 0, 1, 2, 0, 0, -1);
    run_instr(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, -1);
    run_instr(1, 1, 0, 1, 0, 0, 1, 1, 0, 1, 1, -1);
    run_instr(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, -1);

    // Abort mid-RUN at cnt=17
    run_instr(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 17);
    check("pc_en_before_abort", {31'd0, obs[9]}, 32'd1);
    rst_a = 1'b1;
    #1;
    check("outputs_in_reset", {19'd0, obs}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_a = 1'b0;
    @(negedge clk);
    check("idle_bubble", {19'd0, obs}, 32'd0);
    @(negedge clk);
    check("fetch_after_idle", {19'd0, obs}, 32'h1000);
    rst_a = 1'b1;

    // W=4 with CSR
    sel = 1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    run_instr(4, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0, -1);
    run_instr(4, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, -1);
    rst_b = 1'b1;

    // W=1 without CSR: trap never reported
    sel = 2;
    @(posedge clk); #1;
    rst_c = 1'b0;
    run_instr(1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, -1);
    run_instr(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, -1);

    check("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    checks++;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
